mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Main control unit of the multicycle MIPS core. It sequences the shared datapath: one ALU, one memory port and the select lines of the datapath muxes (IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB 4-way, PCSource 8-way). It decodes the 6-bit opcode latched in IR and walks a Moore state machine per instruction class. Memory accesses use a ready handshake with a wait timeout that traps to the exception vector.

## Interface

- WAIT_LIMIT, 16: maximum cycles spent in one memory wait state before a timeout exception; 0 disables the timeout.
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; forces START and all outputs 0
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed current read/write this cycle
- pc_we  out  1  PC write strobe
- ir_we  out  1  IR write strobe
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- reg_we  out  1  register file write strobe
- sel_iord  out  1  0 = PC, 1 = ALUOut as memory address
- sel_regdst  out  1  0 = rt, 1 = rd
- sel_memtoreg  out  1  0 = ALUOut, 1 = MDR
- sel_alusrca  out  1  0 = PC, 1 = A
- sel_alusrcb  out  2  00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2
- sel_pcsrc  out  3  000 ALU result, 001 ALUOut, 010 jump target, 011 exception vector; 100–111 never driven
- alu_op  out  2  00 add, 01 sub, 10 by funct
- exc  out  1  one-cycle pulse in EXC
- exc_cause  out  2  01 illegal opcode, 10 memory timeout; 00 outside EXC
- state_dbg  out  4  current state encoding

## Operation

- State encodings: START 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, ADDI_EXEC 10, ADDI_WB 11, JUMP 12, EXC 13. Codes 14–15 are unreachable and go to START.
- Outputs are decoded combinationally from the state register. pc_we and ir_we are additionally qualified by mem_ready or zero as noted. Any output not listed for a state is 0.
- START: all 0. Next state is FETCH.
- FETCH: mem_rd=1, iord=0, alusrca=0, alusrcb=01, alu_op=00, pcsrc=000. On mem_ready: ir_we=1, pc_we=1, next DECODE. Otherwise hold.
- DECODE: alusrca=0, alusrcb=11, alu_op=00. Dispatch on opcode:
  - 0x00 → R_EXEC
  - 0x23, 0x2B → MEM_ADDR
  - 0x04, 0x05 → BRANCH
  - 0x08 → ADDI_EXEC
  - 0x02 → JUMP
  - any other opcode → EXC with cause 01
- MEM_ADDR: alusrca=1, alusrcb=10, alu_op=00. Opcode 0x23 → MEM_READ; 0x2B → MEM_WRITE.
- MEM_READ: mem_rd=1, iord=1. On mem_ready → MEM_WB.
- MEM_WB: reg_we=1, regdst=0, memtoreg=1. Next FETCH.
- MEM_WRITE: mem_wr=1, iord=1. On mem_ready → FETCH.
- R_EXEC: alusrca=1, alusrcb=00, alu_op=10. Next R_WB.
- R_WB: reg_we=1, regdst=1, memtoreg=0. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, alu_op=01, pcsrc=001. pc_we = zero for 0x04, ~zero for 0x05. Next FETCH.
- ADDI_EXEC: alusrca=1, alusrcb=10, alu_op=00. Next ADDI_WB.
- ADDI_WB: reg_we=1, regdst=0, memtoreg=0. Next FETCH.
- JUMP: pcsrc=010, pc_we=1. Next FETCH.
- EXC: pcsrc=011, pc_we=1, exc=1, exc_cause = latched cause. Next FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE; increments each cycle spent waiting without mem_ready.
  - When WAIT_LIMIT≠0 and the counter equals WAIT_LIMIT-1 with mem_ready still low, next state is EXC with cause 10.
  - If mem_ready arrives in that same cycle, mem_ready wins.
- The cause register is written only on a transition into EXC.

## Timing

- Reset: asserting reset forces the state to START and all outputs to 0 within the same cycle, asynchronously, including mid-access (mem_wr drops immediately). The wait counter and cause register clear. The first FETCH occurs 1 cycle after reset release.
- Cycle counts with mem_ready held high:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, bne, j: 3
  - illegal opcode: 3 (FETCH, DECODE, EXC)
- Each cycle mem_ready is low in a wait state adds 1 cycle.
- mem_rd and mem_wr stay high continuously until the mem_ready cycle, or until the timeout transition.
- opcode must stay stable from DECODE until FETCH; the block does not latch it.

## Test plan

- Reset mid-MEM_WRITE with mem_ready low → mem_wr=0 and state_dbg=0 before the next edge; FETCH follows 1 cycle after release.
- lw (0x23), mem_ready=1 → state_dbg sequence 1,2,3,4,5,1; MEM_WB has reg_we=1 and memtoreg=1.
- beq (0x04) with zero=1 → pc_we=1 and pcsrc=001 in BRANCH. Repeat with zero=0 → pc_we=0. Repeat with bne (0x05) and zero=0 → pc_we=1.
- FETCH with mem_ready low for 3 cycles, WAIT_LIMIT=16 → ir_we=0 for 3 cycles, then ir_we=pc_we=1 and next state DECODE.
- MEM_READ with mem_ready never asserted, WAIT_LIMIT=16 → after 16 wait cycles state=13, exc=1 for one cycle, exc_cause=10, pcsrc=011; also check mem_ready arriving on cycle 16 completes normally.
- Opcode 0x3F → 1,2,13,1 with exc_cause=01. R-type with mem_ready=1 → 1,2,7,8,1 with regdst=1 and alu_op=10.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM of the multicycle MIPS core. Walks one Moore state
// sequence per instruction class and drives the datapath control lines:
// write strobes, memory requests, mux selects and the ALU operation.
// Memory waits are bounded by a wait counter. A timeout traps to the
// exception state, as does an illegal opcode.
//
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   opcode[5:0]       IR[31:26], must stay stable from DECODE until FETCH
//   zero              ALU zero flag, used by beq/bne
//   mem_ready         memory finished the current access this cycle
//   pc_we, ir_we      PC / IR write strobes
//   mem_rd, mem_wr    memory read / write requests
//   reg_we            register file write strobe
//   sel_*             datapath mux selects (iord, regdst, memtoreg,
//                     alusrca, alusrcb[1:0], pcsrc[2:0])
//   alu_op[1:0]       00 add, 01 sub, 10 by funct
//   exc, exc_cause    exception pulse and cause (01 illegal, 10 timeout)
//   state_dbg[3:0]    current state encoding
module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       sel_iord,
  output logic       sel_regdst,
  output logic       sel_memtoreg,
  output logic       sel_alusrca,
  output logic [1:0] sel_alusrcb,
  output logic [2:0] sel_pcsrc,
  output logic [1:0] alu_op,
  output logic       exc,
  output logic [1:0] exc_cause,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12,
    S_EXC       = 4'd13
  } state_t;

  // Counter only needs to reach WAIT_LIMIT-1; with the timeout disabled
  // it simply wraps, which is harmless.
  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t        state, state_next;
  logic [1:0]    cause, cause_next;
  logic [CW-1:0] wait_cnt;
  logic          timeout;
  logic          in_wait;

  assign in_wait = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  // mem_ready in the last allowed cycle takes priority over the timeout.
  assign timeout = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT_M1) && !mem_ready;

  always_comb begin
    state_next = state;
    cause_next = 2'b00;
    case (state)
      S_START: state_next = S_FETCH;
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) begin
          case (state)
            S_FETCH:    state_next = S_DECODE;
            S_MEM_READ: state_next = S_MEM_WB;
            default:    state_next = S_FETCH;
          endcase
        end else if (timeout) begin
          state_next = S_EXC;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          6'h00:        state_next = S_R_EXEC;
          6'h23, 6'h2B: state_next = S_MEM_ADDR;
          6'h04, 6'h05: state_next = S_BRANCH;
          6'h08:        state_next = S_ADDI_EXEC;
          6'h02:        state_next = S_JUMP;
          default: begin
            state_next = S_EXC;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR:  state_next = (opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
      S_R_EXEC:    state_next = S_R_WB;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP, S_EXC: state_next = S_FETCH;
      default:     state_next = S_START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_START;
      wait_cnt <= '0;
      cause    <= 2'b00;
    end else begin
      state <= state_next;
      // Any state change clears the counter, which covers entry to each wait state.
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (in_wait) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (state_next == S_EXC && state != S_EXC) begin
        cause <= cause_next;
      end
    end
  end

  always_comb begin
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    reg_we       = 1'b0;
    sel_iord     = 1'b0;
    sel_regdst   = 1'b0;
    sel_memtoreg = 1'b0;
    sel_alusrca  = 1'b0;
    sel_alusrcb  = 2'b00;
    sel_pcsrc    = 3'b000;
    alu_op       = 2'b00;
    exc          = 1'b0;
    exc_cause    = 2'b00;
    case (state)
      S_FETCH: begin
        mem_rd      = 1'b1;
        sel_alusrcb = 2'b01;
        ir_we       = mem_ready;
        pc_we       = mem_ready;
      end
      S_DECODE:    sel_alusrcb = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        sel_alusrca = 1'b1;
        sel_alusrcb = 2'b10;
      end
      S_MEM_READ: begin
        mem_rd   = 1'b1;
        sel_iord = 1'b1;
      end
      S_MEM_WB: begin
        reg_we       = 1'b1;
        sel_memtoreg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_wr   = 1'b1;
        sel_iord = 1'b1;
      end
      S_R_EXEC: begin
        sel_alusrca = 1'b1;
        alu_op      = 2'b10;
      end
      S_R_WB: begin
        reg_we     = 1'b1;
        sel_regdst = 1'b1;
      end
      S_BRANCH: begin
        sel_alusrca = 1'b1;
        alu_op      = 2'b01;
        sel_pcsrc   = 3'b001;
        // opcode[0] separates bne (0x05) from beq (0x04).
        pc_we       = opcode[0] ? ~zero : zero;
      end
      S_ADDI_WB:   reg_we = 1'b1;
      S_JUMP: begin
        sel_pcsrc = 3'b010;
        pc_we     = 1'b1;
      end
      S_EXC: begin
        sel_pcsrc = 3'b011;
        pc_we     = 1'b1;
        exc       = 1'b1;
        exc_cause = cause;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule
